// File: rtl/branch_resolve_if.sv
// branch_resolve_if: X-stage branch request and registered M-stage resolution bundle.
interface branch_resolve_if #(
   parameter int XLEN = 32
);
   logic            x_valid;
   logic [2:0]      x_funct3;
   logic [XLEN-1:0] x_rs1;
   logic [XLEN-1:0] x_rs2;
   logic [XLEN-1:0] x_pc;
   logic [XLEN-1:0] x_target;
   logic            x_pred_taken;
   logic            m_valid;
   logic            m_taken;
   logic            m_mispredict;
   logic [XLEN-1:0] m_redirect_pc;
   logic            m_illegal;

   modport master (
      output x_valid, x_funct3, x_rs1, x_rs2, x_pc, x_target, x_pred_taken,
      input  m_valid, m_taken, m_mispredict, m_redirect_pc, m_illegal
   );

   modport slave (
      input  x_valid, x_funct3, x_rs1, x_rs2, x_pc, x_target, x_pred_taken,
      output m_valid, m_taken, m_mispredict, m_redirect_pc, m_illegal
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches into the M stage, trains a bimodal
// predictor read by fetch, and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  f_pc_i,
   output logic             f_pred_taken_o,
   input  logic             stall_i,
   input  logic             flush_i,
   branch_resolve_if.slave  x_if,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);
   localparam int IDX = $clog2(DEPTH);

   logic [1:0]       pht_q [DEPTH];
   logic [1:0]       pht_cur, pht_d;
   logic [IDX-1:0]   f_idx, x_idx;
   logic             eq, lt, ltu, taken, illegal, accept, train, mispred;
   logic [XLEN-1:0]  redirect;
   logic             m_valid_q, m_taken_q, m_mispredict_q, m_illegal_q;
   logic             m_valid_d, m_taken_d, m_mispredict_d, m_illegal_d;
   logic [XLEN-1:0]  m_redirect_q, m_redirect_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
   logic             unused_pc;

   assign f_idx          = f_pc_i[IDX+1:2];
   assign x_idx          = x_if.x_pc[IDX+1:2];
   assign unused_pc      = ^{f_pc_i[XLEN-1:IDX+2], f_pc_i[1:0]};
   assign f_pred_taken_o = pht_q[f_idx][1];

   always_comb begin
      eq       = x_if.x_rs1 == x_if.x_rs2;
      lt       = $signed(x_if.x_rs1) < $signed(x_if.x_rs2);
      ltu      = x_if.x_rs1 < x_if.x_rs2;
      illegal  = x_if.x_funct3[2:1] == 2'b01;
      // funct3[0] inverts the base comparison: ne/ge/geu
      taken    = x_if.x_funct3[2] ? ((x_if.x_funct3[1] ? ltu : lt) ^ x_if.x_funct3[0])
                                  : (!x_if.x_funct3[1] & (eq ^ x_if.x_funct3[0]));
      accept   = x_if.x_valid & !stall_i & !flush_i;
      train    = accept & !illegal;
      mispred  = taken != x_if.x_pred_taken;
      redirect = taken ? x_if.x_target : x_if.x_pc + XLEN'(4);
      pht_cur  = pht_q[x_idx];
      pht_d    = taken ? pht_cur + {1'b0, ~&pht_cur} : pht_cur - {1'b0, |pht_cur};
      m_valid_d      = accept;
      m_taken_d      = train & taken;
      m_mispredict_d = train & mispred;
      m_illegal_d    = accept & illegal;
      m_redirect_d   = accept ? redirect : '0;
      branch_cnt_d   = branch_cnt_q + CNT_W'(train & ~&branch_cnt_q);
      mispred_cnt_d  = mispred_cnt_q + CNT_W'(train & mispred & ~&mispred_cnt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q      <= 1'b0;
         m_taken_q      <= 1'b0;
         m_mispredict_q <= 1'b0;
         m_illegal_q    <= 1'b0;
         m_redirect_q   <= '0;
         branch_cnt_q   <= '0;
         mispred_cnt_q  <= '0;
      end else if (!stall_i) begin
         m_valid_q      <= m_valid_d;
         m_taken_q      <= m_taken_d;
         m_mispredict_q <= m_mispredict_d;
         m_illegal_q    <= m_illegal_d;
         m_redirect_q   <= m_redirect_d;
         branch_cnt_q   <= branch_cnt_d;
         mispred_cnt_q  <= mispred_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pht_q[i] <= 2'b01;
      end else if (train) begin
         pht_q[x_idx] <= pht_d;
      end
   end

   assign x_if.m_valid       = m_valid_q;
   assign x_if.m_taken       = m_taken_q;
   assign x_if.m_mispredict  = m_mispredict_q;
   assign x_if.m_illegal     = m_illegal_q;
   assign x_if.m_redirect_pc = m_redirect_q;
   assign branch_cnt_o       = branch_cnt_q;
   assign mispred_cnt_o      = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed branch vectors with a per-cycle scoreboard of M-stage results.
// Narrow counters let saturation be reached in a short run.
module tb_branch_resolve_unit;
   localparam int XLEN = 32, DEPTH = 64, CNT_W = 4;

   logic             clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, f_pred;
   logic [XLEN-1:0]  f_pc = '0;
   logic [CNT_W-1:0] bcnt, mcnt;

   typedef struct packed {
      logic v, t, m, i;
      logic [31:0] r;
      logic [3:0] bc, mc;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int checks = 0, errors = 0;
   logic [3:0] mbc = '0, mmc = '0;

   branch_resolve_if #(.XLEN(XLEN)) bif ();

   branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .f_pc_i(f_pc), .f_pred_taken_o(f_pred),
      .stall_i(stall), .flush_i(flush), .x_if(bif.slave),
      .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic cmp_out(input string n, input exp_t e);
      chk({n, "_valid"}, 32'(bif.m_valid), 32'(e.v));
      chk({n, "_taken"}, 32'(bif.m_taken), 32'(e.t));
      chk({n, "_mispred"}, 32'(bif.m_mispredict), 32'(e.m));
      chk({n, "_illegal"}, 32'(bif.m_illegal), 32'(e.i));
      chk({n, "_redirect"}, bif.m_redirect_pc, e.r);
      chk({n, "_branch_cnt"}, 32'(bcnt), 32'(e.bc));
      chk({n, "_mispred_cnt"}, 32'(mcnt), 32'(e.mc));
   endtask

   // Monitor: after every edge, a fresh expectation if the edge loaded M, else the held one.
   initial begin : mon
      logic st, rs;
      last = '0;
      forever begin
         @(posedge clk);
         st = stall;
         rs = rst_n;
         #1;
         if (!rs || !rst_n) last = '0;
         else if (st) cmp_out("hold", last);
         else if (q.size() != 0) begin
            last = q.pop_front();
            cmp_out("res", last);
         end else if (bif.m_valid) chk("spurious_m_valid", 32'(bif.m_valid), 32'd0);
      end
   end

   task automatic issue(input logic v, input logic [2:0] f3, input logic [31:0] a, b, pc, tgt,
                        input logic p, s, fl, et, input logic [31:0] er);
      exp_t e;
      logic acc, ill;
      bif.x_valid = v; bif.x_funct3 = f3; bif.x_rs1 = a; bif.x_rs2 = b;
      bif.x_pc = pc; bif.x_target = tgt; bif.x_pred_taken = p;
      stall = s; flush = fl;
      acc = v & !s & !fl;
      ill = f3[2:1] == 2'b01;
      if (!s) begin
         e = '0;
         if (acc) begin
            e.v = 1'b1; e.i = ill; e.t = et; e.r = er;
            if (!ill) begin
               if (mbc != 4'hF) mbc++;
               e.m = et != p;
               if (e.m && mmc != 4'hF) mmc++;
            end
         end
         e.bc = mbc; e.mc = mmc;
         q.push_back(e);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic br(input logic [2:0] f3, input logic [31:0] a, b, pc, tgt, input logic p, et,
                     input logic [31:0] er);
      issue(1'b1, f3, a, b, pc, tgt, p, 1'b0, 1'b0, et, er);
      tick();
   endtask

   task automatic idle();
      issue(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
   endtask

   task automatic pchk(input logic [31:0] pc, input logic e, input string n);
      f_pc = pc;
      #1;
      chk(n, 32'(f_pred), 32'(e));
   endtask

   initial begin
      bif.x_valid = 0; bif.x_funct3 = 0; bif.x_rs1 = 0; bif.x_rs2 = 0;
      bif.x_pc = 0; bif.x_target = 0; bif.x_pred_taken = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      pchk(32'h100, 1'b0, "pred_reset");
      chk("rst_m_valid", 32'(bif.m_valid), 32'd0);
      chk("rst_redirect", bif.m_redirect_pc, 32'd0);
      chk("rst_branch_cnt", 32'(bcnt), 32'd0);
      chk("rst_mispred_cnt", 32'(mcnt), 32'd0);
      idle();
      // compare kinds
      br(3'b100, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h80, 1'b0, 1'b1, 32'h80);
      br(3'b110, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h44);
      br(3'b101, 32'd5, 32'hFFFFFFFD, 32'h60, 32'h10, 1'b1, 1'b1, 32'h10);
      br(3'b111, 32'd5, 32'hFFFFFFFD, 32'h60, 32'h10, 1'b1, 1'b0, 32'h64);
      br(3'b001, 32'd7, 32'd7, 32'h80, 32'h300, 1'b0, 1'b0, 32'h84);
      // predictor training and saturation at pc 0x20
      issue(1'b1, 3'b000, 32'd3, 32'd3, 32'h20, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
      pchk(32'h20, 1'b0, "pred_same_cycle");
      tick();
      pchk(32'h20, 1'b1, "pred_after_first");
      br(3'b000, 32'd3, 32'd3, 32'h20, 32'h200, 1'b1, 1'b1, 32'h200);
      br(3'b000, 32'd3, 32'd3, 32'h20, 32'h200, 1'b1, 1'b1, 32'h200);
      pchk(32'h120, 1'b1, "pred_alias");
      br(3'b000, 32'd3, 32'd4, 32'h20, 32'h200, 1'b1, 1'b0, 32'h24);
      br(3'b000, 32'd3, 32'd4, 32'h20, 32'h200, 1'b1, 1'b0, 32'h24);
      pchk(32'h20, 1'b0, "pred_sat_high");
      br(3'b110, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h44);
      br(3'b110, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h44);
      pchk(32'h40, 1'b0, "pred_sat_low");
      // stall holds M, predictor and counters
      br(3'b001, 32'd1, 32'd2, 32'h80, 32'h300, 1'b0, 1'b1, 32'h300);
      repeat (3) begin
         issue(1'b1, 3'b000, 32'd1, 32'd1, 32'h20, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
         tick();
      end
      pchk(32'h20, 1'b0, "pred_stall");
      br(3'b000, 32'd1, 32'd1, 32'h20, 32'h400, 1'b0, 1'b1, 32'h400);
      // illegal funct3, flush, idle
      br(3'b010, 32'd1, 32'd1, 32'h90, 32'h500, 1'b1, 1'b0, 32'h94);
      br(3'b011, 32'd1, 32'd2, 32'h90, 32'h500, 1'b0, 1'b0, 32'h94);
      issue(1'b1, 3'b000, 32'd1, 32'd1, 32'h90, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      idle();
      // PC wrap and counter saturation
      br(3'b000, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 9; k++)
         br(3'b001, 32'd1, 32'd2, 32'h10, 32'h20, 1'b0, 1'b1, 32'h20);
      pchk(32'h20, 1'b1, "pred_pre_reset");
      // reset mid-operation discards M and re-initialises the predictor
      rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", 32'(bif.m_valid), 32'd0);
      chk("midrst_branch_cnt", 32'(bcnt), 32'd0);
      chk("midrst_mispred_cnt", 32'(mcnt), 32'd0);
      pchk(32'h20, 1'b0, "pred_mid_reset");
      mbc = '0;
      mmc = '0;
      tick();
      rst_n = 1'b1;
      br(3'b000, 32'd3, 32'd3, 32'h20, 32'h30, 1'b0, 1'b1, 32'h30);
      idle();
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
